// File: rtl/nn_main_fsm.sv
// Primary NN accelerator control FSM: issues begin_* commands per layer and waits for done pulses.
// Optional WAIT-state watchdog enabled by defining NN_WATCHDOG_EN.
module nn_main_fsm #(
  parameter int STAGE_W         = 8,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               registers_initialized,
  input  logic               data_loaded,
  input  logic               data_processed,
  input  logic               output_written,
  input  logic [STAGE_W-1:0] totalLayerNumber,
  output logic               begin_initialize_registers,
  output logic               begin_load_data,
  output logic               begin_process_data,
  output logic               begin_write_output,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [3:0] {
    IDLE, INIT_REQ, INIT_WAIT, CHECK, LOAD_REQ, LOAD_WAIT,
    PROC_REQ, PROC_WAIT, NEXT, WRITE_REQ, WRITE_WAIT, HALT
  } state_t;

  state_t             state_reg, state_next;
  logic [STAGE_W-1:0] stage_next;
  logic               done_next, error_next;
  logic [STAGE_W:0]   stage_inc;
  logic               wd_expired;

  // One extra bit so a layer count near the top of the range cannot wrap.
  assign stage_inc = {1'b0, stage} + {{STAGE_W{1'b0}}, 1'b1};

`ifdef NN_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;

  assign in_wait = (state_reg == INIT_WAIT) || (state_reg == LOAD_WAIT) ||
                   (state_reg == PROC_WAIT) || (state_reg == WRITE_WAIT);
  assign wd_expired = in_wait && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

  // Every WAIT state is entered from a REQ state, so clearing outside WAIT restarts the count on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wd_cnt <= '0;
    else if (in_wait) wd_cnt <= wd_cnt + 1'b1;
    else              wd_cnt <= '0;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    stage_next = stage;
    done_next  = done;
    error_next = error;
    case (state_reg)
      IDLE: if (start) begin
        state_next = INIT_REQ;
        stage_next = STAGE_W'(1);
        done_next  = 1'b0;
        error_next = 1'b0;
      end
      INIT_REQ:  state_next = INIT_WAIT;
      INIT_WAIT: if (registers_initialized) state_next = CHECK;
                 else if (wd_expired) begin state_next = HALT; error_next = 1'b1; end
      CHECK: if (totalLayerNumber < STAGE_W'(2)) begin
               state_next = HALT;
               error_next = 1'b1;
             end else state_next = LOAD_REQ;
      LOAD_REQ:  state_next = LOAD_WAIT;
      LOAD_WAIT: if (data_loaded) state_next = PROC_REQ;
                 else if (wd_expired) begin state_next = HALT; error_next = 1'b1; end
      PROC_REQ:  state_next = PROC_WAIT;
      PROC_WAIT: if (data_processed) state_next = NEXT;
                 else if (wd_expired) begin state_next = HALT; error_next = 1'b1; end
      NEXT: if (stage_inc < {1'b0, totalLayerNumber}) begin
              state_next = LOAD_REQ;
              stage_next = stage_inc[STAGE_W-1:0];
            end else state_next = WRITE_REQ;
      WRITE_REQ:  state_next = WRITE_WAIT;
      WRITE_WAIT: if (output_written) begin state_next = HALT; done_next = 1'b1; end
                  else if (wd_expired) begin state_next = HALT; error_next = 1'b1; end
      HALT: if (!start) begin
              state_next = IDLE;
              done_next  = 1'b0;
              error_next = 1'b0;
            end
      default: state_next = IDLE;
    endcase
  end

  // Command strobes decode the next state so they are high exactly while in the REQ state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg                  <= IDLE;
      begin_initialize_registers <= 1'b0;
      begin_load_data            <= 1'b0;
      begin_process_data         <= 1'b0;
      begin_write_output         <= 1'b0;
      stage                      <= '0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      error                      <= 1'b0;
    end else begin
      state_reg                  <= state_next;
      begin_initialize_registers <= (state_next == INIT_REQ);
      begin_load_data            <= (state_next == LOAD_REQ);
      begin_process_data         <= (state_next == PROC_REQ);
      begin_write_output         <= (state_next == WRITE_REQ);
      stage                      <= stage_next;
      busy                       <= (state_next != IDLE) && (state_next != HALT);
      done                       <= done_next;
      error                      <= error_next;
    end
  end

endmodule

// File: tb/tb_nn_main_fsm.sv
// Randomized scoreboard bench for nn_main_fsm with a behavioural secondary-FSM responder.
module tb_nn_main_fsm;
  localparam int STAGE_W = 8;
  localparam int WD      = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic registers_initialized = 1'b0;
  logic data_loaded = 1'b0;
  logic data_processed = 1'b0;
  logic output_written = 1'b0;
  logic [STAGE_W-1:0] total_layers = '0;
  logic begin_initialize_registers, begin_load_data, begin_process_data, begin_write_output;
  logic [STAGE_W-1:0] stage;
  logic busy, done, error;

  nn_main_fsm #(.STAGE_W(STAGE_W), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .registers_initialized(registers_initialized), .data_loaded(data_loaded),
    .data_processed(data_processed), .output_written(output_written),
    .totalLayerNumber(total_layers),
    .begin_initialize_registers(begin_initialize_registers),
    .begin_load_data(begin_load_data), .begin_process_data(begin_process_data),
    .begin_write_output(begin_write_output),
    .stage(stage), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int stg; } cmd_t;   // kind: 0 init, 1 load, 2 proc, 3 write
  cmd_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int lat_min = 5, lat_max = 5;
  int pend_kind = -1, pend_cnt = 0;
  bit withhold_load = 1'b0;
  bit force_load = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int cmd_seen();
    if (begin_initialize_registers) return 0;
    if (begin_load_data)            return 1;
    if (begin_process_data)         return 2;
    if (begin_write_output)         return 3;
    return -1;
  endfunction

  task automatic drive(input int k);
    case (k)
      0: registers_initialized = 1'b1;
      1: data_loaded           = 1'b1;
      2: data_processed        = 1'b1;
      default: output_written  = 1'b1;
    endcase
  endtask

  // Secondary FSM model: answers each command after a random latency, with stray wrong-kind pulses meanwhile.
  always @(negedge clk) begin
    registers_initialized = 1'b0;
    data_loaded = 1'b0;
    data_processed = 1'b0;
    output_written = 1'b0;
    if (!reset_n) begin
      pend_kind = -1;
    end else begin
      if (force_load) begin
        data_loaded = 1'b1;
        force_load = 1'b0;
      end
      if (pend_kind >= 0) begin
        if (pend_cnt <= 1) begin
          drive(pend_kind);
          pend_kind = -1;
        end else begin
          pend_cnt--;
          if ($urandom_range(0, 3) == 0) drive((pend_kind + 1 + int'($urandom_range(0, 2))) % 4);
        end
      end
      if (cmd_seen() >= 0 && !(withhold_load && cmd_seen() == 1)) begin
        pend_kind = cmd_seen();
        pend_cnt  = int'($urandom_range(lat_min, lat_max));
      end
    end
  end

  // Monitor: every command strobe is popped against the reference command list.
  always @(negedge clk) begin
    if (reset_n) begin
      int nb;
      nb = int'(begin_initialize_registers) + int'(begin_load_data) +
           int'(begin_process_data) + int'(begin_write_output);
      if (nb > 1) chk("cmd_onehot", nb, 1);
      else if (nb == 1) begin
        if (exp_q.size() == 0) chk("unexpected_cmd", cmd_seen(), -1);
        else begin
          cmd_t e;
          e = exp_q.pop_front();
          chk("cmd_kind", cmd_seen(), e.kind);
          chk("cmd_stage", int'(stage), e.stg);
        end
      end
    end
  end

  // Reference: an N-layer network needs init, N-1 load/process pairs, then write.
  task automatic plan_run(input int n);
    exp_q.push_back('{0, 1});
    if (n >= 2) begin
      for (int s = 1; s < n; s++) begin
        exp_q.push_back('{1, s});
        exp_q.push_back('{2, s});
      end
      exp_q.push_back('{3, n - 1});
    end
  endtask

  task automatic do_run(input int n, input bit hold);
    int t;
    total_layers = STAGE_W'(n);
    plan_run(n);
    start = 1'b1;
    @(negedge clk);
    chk("busy_rise", int'(busy), 1);
    t = 0;
    while (!(done || error) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("run_timeout", int'(t < 20000), 1);
    chk("end_done", int'(done), int'(n >= 2));
    chk("end_error", int'(error), int'(n < 2));
    chk("end_busy", int'(busy), 0);
    chk("cmds_missing", exp_q.size(), 0);
    chk("end_stage", int'(stage), (n >= 2) ? n - 1 : 1);
    if (hold) begin
      repeat (20) @(negedge clk);
      chk("hold_done", int'(done), int'(n >= 2));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", int'(done), 0);
    chk("idle_error", int'(error), 0);
    chk("idle_busy", int'(busy), 0);
    exp_q.delete();
    $display("run n=%0d hold=%0d cycles=%0d errors=%0d", n, hold, t, errors);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({begin_initialize_registers, begin_load_data, begin_process_data,
                    begin_write_output, busy, done, error}) + int'(stage), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("post_reset_idle");

    do_run(4, 1'b1);
    do_run(2, 1'b0);
    do_run(1, 1'b0);
    do_run(0, 1'b0);
    lat_min = 1; lat_max = 3;
    do_run(255, 1'b0);
    lat_min = 1; lat_max = 6;
    repeat (6) do_run(int'($urandom_range(0, 9)), bit'($urandom_range(0, 1)));

    // Asynchronous reset during PROC_WAIT at stage 2.
    lat_min = 5; lat_max = 5;
    total_layers = 8'd4;
    plan_run(4);
    start = 1'b1;
    t = 0;
    while (!(begin_process_data && stage == 2) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reach_proc2", int'(t < 500), 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_all_zero("idle_after_reset");
    do_run(3, 1'b0);

`ifdef NN_WATCHDOG_EN
    begin
      int c0;
      withhold_load = 1'b1;
      total_layers = 8'd4;
      exp_q.push_back('{0, 1});
      exp_q.push_back('{1, 1});
      start = 1'b1;
      t = 0;
      while (!begin_load_data && t < 200) begin
        @(negedge clk);
        t++;
      end
      c0 = cycle;
      t = 0;
      while (!error && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("wd_delay", cycle - c0, WD + 1);
      chk("wd_done", int'(done), 0);
      chk("wd_busy", int'(busy), 0);
      force_load = 1'b1;
      repeat (10) @(negedge clk);
      chk("wd_late_error", int'(error), 1);
      chk("wd_late_busy", int'(busy), 0);
      start = 1'b0;
      withhold_load = 1'b0;
      repeat (2) @(negedge clk);
      chk("wd_clear", int'(error), 0);
      $display("watchdog run errors=%0d", errors);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
